// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-mul/div handshake: op request, flush and HI/LO read in; status and HI/LO out.
interface ex_muldiv_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hilo_rd;
  logic              cancel;
  logic              busy;
  logic              done;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hilo_rd, cancel,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_rd, cancel,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit owning HI/LO; one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, signs applied on completion.
module ex_muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;      // product high half / partial remainder
  logic [DATA_W-1:0] wrk_q;      // multiplier->product low half / dividend->quotient
  logic [DATA_W-1:0] opnd_q;     // multiplicand or divisor magnitude
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              is_div_q;
  logic              div0_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              busy_q;
  logic              done_q;

  logic              op_muldiv_c;
  logic              op_div_c;
  logic              op_signed_c;
  logic              sign_a_c;
  logic              sign_b_c;
  logic [DATA_W-1:0] mag_a_c;
  logic [DATA_W-1:0] mag_b_c;
  logic              accept_c;

  logic [DATA_W:0]   mul_sum_c;
  logic [DATA_W:0]   rem_sh_c;
  logic              rem_fit_c;
  logic [DATA_W-1:0] rem_sub_c;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] prod_sgn_c;
  logic [DATA_W-1:0] quo_sgn_c;
  logic [DATA_W-1:0] rem_sgn_c;

  // Op decode and operand magnitudes for the request in ID/EX
  always_comb begin
    op_muldiv_c = 1'b0;
    op_div_c    = 1'b0;
    op_signed_c = 1'b0;
    case (bus.op)
      OP_MULT:  begin op_muldiv_c = 1'b1; op_signed_c = 1'b1; end
      OP_MULTU: begin op_muldiv_c = 1'b1; end
      OP_DIV:   begin op_muldiv_c = 1'b1; op_signed_c = 1'b1; op_div_c = 1'b1; end
      OP_DIVU:  begin op_muldiv_c = 1'b1; op_div_c = 1'b1; end
      default:  ;
    endcase
    sign_a_c = op_signed_c & bus.rs_val[DATA_W-1];
    sign_b_c = op_signed_c & bus.rt_val[DATA_W-1];
    mag_a_c  = sign_a_c ? (~bus.rs_val + DATA_W'(1)) : bus.rs_val;
    mag_b_c  = sign_b_c ? (~bus.rt_val + DATA_W'(1)) : bus.rt_val;
    accept_c = (state_q == S_IDLE) & bus.start & ~bus.cancel;
  end

  // Single iteration step and final sign correction
  always_comb begin
    mul_sum_c  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : {(DATA_W + 1){1'b0}});
    rem_sh_c   = {acc_q, wrk_q[DATA_W-1]};
    rem_fit_c  = rem_sh_c >= {1'b0, opnd_q};
    rem_sub_c  = rem_sh_c[DATA_W-1:0] - opnd_q;
    prod_c     = {acc_q, wrk_q};
    prod_sgn_c = neg_res_q ? (~prod_c + PROD_W'(1)) : prod_c;
    quo_sgn_c  = neg_res_q ? (~wrk_q + DATA_W'(1)) : wrk_q;
    rem_sgn_c  = neg_rem_q ? (~acc_q + DATA_W'(1)) : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c && op_muldiv_c) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_div_c;
            div0_q    <= op_div_c & (bus.rt_val == '0);
            neg_res_q <= sign_a_c ^ sign_b_c;
            neg_rem_q <= sign_a_c;
            rs_q      <= bus.rs_val;
            acc_q     <= '0;
            wrk_q     <= op_div_c ? mag_a_c : mag_b_c;
            opnd_q    <= op_div_c ? mag_b_c : mag_a_c;
          end else if (accept_c && bus.op == OP_MTHI) begin
            hi_q <= bus.rs_val;
          end else if (accept_c && bus.op == OP_MTLO) begin
            lo_q <= bus.rs_val;
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (is_div_q) begin
              acc_q <= rem_fit_c ? rem_sub_c : rem_sh_c[DATA_W-1:0];
              wrk_q <= {wrk_q[DATA_W-2:0], rem_fit_c};
            end else begin
              acc_q <= mul_sum_c[DATA_W:1];
              wrk_q <= {mul_sum_c[0], wrk_q[DATA_W-1:1]};
            end
            if (cnt_q == LAST_ITER) begin
              state_q <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (div0_q) begin
              hi_q <= rs_q;
              lo_q <= '1;
            end else if (is_div_q) begin
              hi_q <= rem_sgn_c;
              lo_q <= quo_sgn_c;
            end else begin
              hi_q <= prod_sgn_c[PROD_W-1:DATA_W];
              lo_q <= prod_sgn_c[DATA_W-1:0];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must drop in the very cycle busy falls, so it is not registered
  assign bus.stall = busy_q & (bus.start | bus.hilo_rd);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
